lsu_mem_master: RTL and testbench

//  Load/store sequencer in the MEM stage; initiator side of the byte-wide data memory port.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_wait_cnt.sv | 27 ++
 rtl/lsu_mem_master.sv | 122 ++++++++++++
 tb/tb_lsu_mem_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the MEM-stage load/store sequencer.
// The state enum and the word-split decision are used by the top and its helpers.
package lsu_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int RD_LAT_DEF = 1;
  localparam int BYTE_W     = 8;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } lsu_state_t;

  // A word access still owes its high byte while the lane index is 0.
  function automatic logic need_high(input logic byte_acc, input logic idx);
    return !byte_acc && !idx;
  endfunction

endpackage

// File: rtl/lsu_wait_cnt.sv
// Loadable down-counter that paces the wait for read data from the byte memory.
// Loads RD_LAT-1 on issue and flags zero when the read byte is due.
module lsu_wait_cnt import lsu_pkg::*; #(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(RD_LAT - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store sequencer driving a byte-wide data memory; words are split into
// two little-endian byte accesses and byte loads are zero-extended.
module lsu_mem_master import lsu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] wdata_hi_q;
  logic [BYTE_W-1:0] lane0_q;
  logic              write_q, byte_q, idx_q;
  logic              accept, more, step, step_high, load_done;
  logic              cnt_load, cnt_zero;

  assign accept    = req_valid && req_ready;
  assign more      = need_high(byte_q, idx_q);
  assign cnt_load  = (state == ISSUE) && !write_q;
  // Stores leave ISSUE at once; loads leave WAIT when the read byte has arrived.
  assign step      = ((state == ISSUE) && write_q) || ((state == WAIT) && cnt_zero);
  assign step_high = step && more;
  assign load_done = (state == WAIT) && cnt_zero && !more;

  lsu_wait_cnt #(
    .RD_LAT(RD_LAT)
  ) u_wait_cnt (
    .clk  (clk),
    .reset(reset),
    .load (cnt_load),
    .dec  (state == WAIT),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
      ISSUE:   begin
        if (!write_q) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = more ? ISSUE : DONE;
        end
      end
      WAIT:    if (cnt_zero) state_nxt = more ? ISSUE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = reset && (state == IDLE);
    rsp_valid = reset && (state == DONE);
    mem_en    = reset && (state == ISSUE);
    mem_we    = mem_en && write_q;
  end

  // The memory address/data registers are loaded only when entering ISSUE,
  // so they hold their last value in every other state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q     <= '0;
      wdata_hi_q <= '0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      idx_q      <= 1'b0;
      lane0_q    <= '0;
      rsp_rdata  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        wdata_hi_q <= req_wdata[15:8];
        write_q    <= req_write;
        byte_q     <= req_byte;
        idx_q      <= 1'b0;
        mem_addr   <= req_addr;
        mem_wdata  <= req_wdata[7:0];
      end
      if (step_high) begin
        idx_q     <= 1'b1;
        mem_addr  <= addr_q + ADDR_W'(1);
        mem_wdata <= wdata_hi_q;
      end
      if ((state == WAIT) && cnt_zero && !idx_q) begin
        lane0_q <= mem_rdata;
      end
      if (load_done) begin
        rsp_rdata <= byte_q ? {8'h00, mem_rdata} : {mem_rdata, lane0_q};
      end
      if (state == DONE) begin
        idx_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests push expected responses
// and memory accesses; negedge monitors pop and compare what the DUTs present.
module tb_lsu_mem_master;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          due;
  } mem_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: RD_LAT=1
  logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_req_byte = 1'b0;
  logic [15:0] a_req_addr = '0, a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid, a_mem_en, a_mem_we;
  logic [15:0] a_rsp_rdata, a_mem_addr;
  logic [7:0]  a_mem_wdata, a_mem_rdata;

  // Instance b: RD_LAT=3
  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_byte = 1'b0;
  logic [15:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_mem_en, b_mem_we;
  logic [15:0] b_rsp_rdata, b_mem_addr;
  logic [7:0]  b_mem_wdata, b_mem_rdata;

  lsu_mem_master #(.ADDR_W(16), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_byte(a_req_byte), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  lsu_mem_master #(.ADDR_W(16), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_byte(b_req_byte), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Byte memories; read data is poisoned to 0xEE when no read was issued so a
  // mistimed capture shows up as wrong data.
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (!reset) begin
      mem_a[16'h0004] <= 8'h12;
      mem_a[16'h0005] <= 8'h43;
      mem_a[16'h0007] <= 8'hBE;
      mem_a[16'hFFFF] <= 8'h11;
      mem_a[16'h0000] <= 8'h22;
    end else if (a_mem_en && a_mem_we) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
    end
    pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : 8'hEE;
  end
  assign a_mem_rdata = pipe_a;

  always @(posedge clk) begin
    if (!reset) begin
      mem_b[16'h0004] <= 8'h12;
      mem_b[16'h0005] <= 8'h43;
      mem_b[16'h0007] <= 8'hBE;
    end else if (b_mem_en && b_mem_we) begin
      mem_b[b_mem_addr] <= b_mem_wdata;
    end
    pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 8'hEE;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  rsp_exp_t a_rsp_q[$];
  rsp_exp_t b_rsp_q[$];
  mem_exp_t a_mem_q[$];
  rsp_exp_t a_rsp_e, b_rsp_e;
  mem_exp_t a_mem_e;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (a_rsp_valid) begin
      if (a_rsp_q.size() == 0) begin
        checkOutput("a_rsp_unexpected", 32'(a_rsp_valid), 32'd0);
      end else begin
        a_rsp_e = a_rsp_q.pop_front();
        checkOutput("a_rsp_cycle", cyc, a_rsp_e.due);
        checkOutput("a_rsp_rdata", 32'(a_rsp_rdata), 32'(a_rsp_e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (a_mem_en) begin
      if (a_mem_q.size() == 0) begin
        checkOutput("a_mem_unexpected", 32'(a_mem_en), 32'd0);
      end else begin
        a_mem_e = a_mem_q.pop_front();
        checkOutput("a_mem_cycle", cyc, a_mem_e.due);
        checkOutput("a_mem_addr", 32'(a_mem_addr), 32'(a_mem_e.addr));
        checkOutput("a_mem_we", 32'(a_mem_we), 32'(a_mem_e.we));
        if (a_mem_e.we) checkOutput("a_mem_wdata", 32'(a_mem_wdata), 32'(a_mem_e.wdata));
      end
    end
    if (a_mem_we && !a_mem_en) checkOutput("a_we_without_en", 32'(a_mem_we), 32'd0);
  end

  always @(negedge clk) begin
    if (b_rsp_valid) begin
      if (b_rsp_q.size() == 0) begin
        checkOutput("b_rsp_unexpected", 32'(b_rsp_valid), 32'd0);
      end else begin
        b_rsp_e = b_rsp_q.pop_front();
        checkOutput("b_rsp_cycle", cyc, b_rsp_e.due);
        checkOutput("b_rsp_rdata", 32'(b_rsp_rdata), 32'(b_rsp_e.data));
      end
    end
  end

  // Issues one request on instance a (RD_LAT=1) from an IDLE negedge, queues the
  // hand-computed response and byte accesses, and waits for completion.
  task automatic applyStimulus(input logic wr, input logic byt, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_rdata);
    int       a;
    int       lat;
    rsp_exp_t r;
    mem_exp_t m;
    lat = wr ? (byt ? 2 : 3) : (byt ? 3 : 5);
    checkOutput("a_req_ready_idle", 32'(a_req_ready), 32'd1);
    a = cyc + 1;
    a_req_valid = 1'b1;
    a_req_write = wr;
    a_req_byte  = byt;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    r.data = exp_rdata;
    r.due  = a + lat - 1;
    a_rsp_q.push_back(r);
    m.we    = wr;
    m.addr  = addr;
    m.wdata = wdata[7:0];
    m.due   = a;
    a_mem_q.push_back(m);
    if (!byt) begin
      m.addr  = addr + 16'd1;
      m.wdata = wdata[15:8];
      m.due   = wr ? a + 1 : a + 2;
      a_mem_q.push_back(m);
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_write = ~wr;
    a_req_byte  = ~byt;
    a_req_addr  = 16'hDEAD;
    a_req_wdata = 16'hBEEF;
    repeat (lat) begin
      checkOutput("a_req_ready_busy", 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 20 && a_rsp_q.size() != 0; i++) @(negedge clk);
    if (a_rsp_q.size() != 0) begin
      checkOutput("a_rsp_timeout", 32'(a_rsp_q.size()), 32'd0);
      a_rsp_q.delete();
      a_mem_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int       a;
    rsp_exp_t r;
    mem_exp_t m;

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(a_req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    checkOutput("reset_mem_en", 32'(a_mem_en), 32'd0);
    checkOutput("reset_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    checkOutput("reset_mem_addr", 32'(a_mem_addr), 32'd0);
    checkOutput("reset_mem_wdata", 32'(a_mem_wdata), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 1'b0, 16'h0004, 16'h0000, 16'h4312);
    applyStimulus(1'b0, 1'b1, 16'h0007, 16'h0000, 16'h00BE);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'hA55A, 16'h00BE);
    checkOutput("mem_wdata_hold", 32'(a_mem_wdata), 32'h0000_00A5);
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA55A);
    checkOutput("mem_addr_hold", 32'(a_mem_addr), 32'h0000_0011);
    applyStimulus(1'b1, 1'b1, 16'h0020, 16'h3377, 16'hA55A);
    applyStimulus(1'b1, 1'b0, 16'h0021, 16'h1234, 16'hA55A);
    applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h3477);
    applyStimulus(1'b0, 1'b1, 16'h0022, 16'h0000, 16'h0012);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h2211);

    // Abort a word load while waiting for its high byte.
    checkOutput("abort_load_ready", 32'(a_req_ready), 32'd1);
    a = cyc + 1;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_byte = 1'b0;
    a_req_addr = 16'h0004; a_req_wdata = 16'h0000;
    m.we = 1'b0; m.wdata = 8'h00;
    m.addr = 16'h0004; m.due = a;     a_mem_q.push_back(m);
    m.addr = 16'h0005; m.due = a + 2; a_mem_q.push_back(m);
    @(negedge clk);
    a_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_load_mem_en", 32'(a_mem_en), 32'd0);
    checkOutput("abort_load_rsp_valid", 32'(a_rsp_valid), 32'd0);
    checkOutput("abort_load_ready_in_reset", 32'(a_req_ready), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(a_req_ready), 32'd1);
    checkOutput("rsp_rdata_after_reset", 32'(a_rsp_rdata), 32'd0);

    // Abort a word store in its first ISSUE cycle.
    a = cyc + 1;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_byte = 1'b0;
    a_req_addr = 16'h0030; a_req_wdata = 16'h9988;
    m.we = 1'b1; m.addr = 16'h0030; m.wdata = 8'h88; m.due = a;
    a_mem_q.push_back(m);
    @(negedge clk);
    a_req_valid = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_store_mem_en", 32'(a_mem_en), 32'd0);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0043);

    // RD_LAT=3 instance: request held valid across two byte loads.
    checkOutput("b_req_ready_idle", 32'(b_req_ready), 32'd1);
    a = cyc + 1;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_byte = 1'b1;
    b_req_addr = 16'h0004; b_req_wdata = 16'h0000;
    r.data = 16'h0012; r.due = a + 4;  b_rsp_q.push_back(r);
    r.data = 16'h00BE; r.due = a + 10; b_rsp_q.push_back(r);
    @(negedge clk);
    b_req_addr = 16'h0007;
    while (cyc < a + 6) @(negedge clk);
    b_req_valid = 1'b0;
    b_req_addr  = 16'hDEAD;
    for (int i = 0; i < 30 && b_rsp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);

    checkOutput("a_rsp_queue_drained", 32'(a_rsp_q.size()), 32'd0);
    checkOutput("a_mem_queue_drained", 32'(a_mem_q.size()), 32'd0);
    checkOutput("b_rsp_queue_drained", 32'(b_rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
